// File: rtl/uart_bridge.sv
// ============================================================================
// Module   : uart_bridge
// Function : 8N1 serial command bridge issuing single-byte reads/writes on the
//            6502-side memory bus and answering with a one-byte response.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_bridge #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        tx,
    input  logic        bus_en,
    output logic        cs,
    output logic        we,
    output logic [15:0] addr,
    output logic [7:0]  dbw,
    input  logic [7:0]  dbr
);

    localparam int c_div  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int c_cw   = $clog2(c_div);
    localparam logic [c_cw-1:0] c_last = c_cw'(c_div - 1);
    localparam logic [c_cw-1:0] c_mid  = c_cw'(c_div / 2 - 1);

    localparam logic [1:0] c_rx_idle  = 2'd0;
    localparam logic [1:0] c_rx_start = 2'd1;
    localparam logic [1:0] c_rx_data  = 2'd2;
    localparam logic [1:0] c_rx_stop  = 2'd3;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_addr_hi = 3'd1;
    localparam logic [2:0] c_st_addr_lo = 3'd2;
    localparam logic [2:0] c_st_data    = 3'd3;
    localparam logic [2:0] c_st_bus     = 3'd4;
    localparam logic [2:0] c_st_capture = 3'd5;
    localparam logic [2:0] c_st_resp    = 3'd6;

    localparam logic [7:0] c_cmd_w    = 8'h57;
    localparam logic [7:0] c_cmd_r    = 8'h52;
    localparam logic [7:0] c_resp_ok  = 8'h2E;
    localparam logic [7:0] c_resp_bad = 8'h3F;

    logic            r_rx_s1, r_rx_s2, r_rx_prev;
    logic [1:0]      r_rx_st;
    logic [c_cw-1:0] r_rx_cnt;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_sh, r_rx_byte;
    logic            r_rx_valid, r_rx_ferr;

    logic            r_tx, r_tx_busy;
    logic [c_cw-1:0] r_tx_cnt;
    logic [3:0]      r_tx_bitn;
    logic [8:0]      r_tx_sh;

    logic [2:0]      r_state, w_next;
    logic            r_op_wr;
    logic [15:0]     r_addr;
    logic [7:0]      r_dbw, r_resp;
    logic            w_rx_take, w_tx_load, w_cs, w_we;

    // Receiver: start re-checked at mid-bit, then every bit sampled at its centre
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_st    <= c_rx_idle;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_sh    <= 8'h00;
            r_rx_byte  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_rx_ferr <= 1'b0;
            if (w_rx_take)
                r_rx_valid <= 1'b0;
            case (r_rx_st)
                c_rx_idle: begin
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_st  <= c_rx_start;
                        r_rx_cnt <= '0;
                    end
                end
                c_rx_start: begin
                    if (r_rx_cnt == c_mid) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= 3'd0;
                        r_rx_st  <= r_rx_s2 ? c_rx_idle : c_rx_data;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                c_rx_data: begin
                    if (r_rx_cnt == c_last) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                        r_rx_bit <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7)
                            r_rx_st <= c_rx_stop;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                c_rx_stop: begin
                    if (r_rx_cnt == c_last) begin
                        r_rx_cnt <= '0;
                        r_rx_st  <= c_rx_idle;
                        if (r_rx_s2) begin
                            r_rx_byte  <= r_rx_sh;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_rx_ferr  <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Transmitter: r_tx_bitn counts start (0), data (1..8), stop (9)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx      <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_cnt  <= '0;
            r_tx_bitn <= 4'd0;
            r_tx_sh   <= 9'h1FF;
        end else if (!r_tx_busy) begin
            if (w_tx_load) begin
                r_tx      <= 1'b0;
                r_tx_busy <= 1'b1;
                r_tx_cnt  <= '0;
                r_tx_bitn <= 4'd0;
                r_tx_sh   <= {1'b1, r_resp};
            end
        end else if (r_tx_cnt == c_last) begin
            r_tx_cnt <= '0;
            if (r_tx_bitn == 4'd9) begin
                r_tx      <= 1'b1;
                r_tx_busy <= 1'b0;
            end else begin
                r_tx      <= r_tx_sh[0];
                r_tx_sh   <= {1'b1, r_tx_sh[8:1]};
                r_tx_bitn <= r_tx_bitn + 4'd1;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= c_st_idle;
        else
            r_state <= w_next;
    end

    // Framing errors abort only while the packet is still being collected
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:
                if (r_rx_valid)
                    w_next = (r_rx_byte == c_cmd_w || r_rx_byte == c_cmd_r) ? c_st_addr_hi : c_st_resp;
            c_st_addr_hi:
                if (r_rx_ferr)       w_next = c_st_idle;
                else if (r_rx_valid) w_next = c_st_addr_lo;
            c_st_addr_lo:
                if (r_rx_ferr)       w_next = c_st_idle;
                else if (r_rx_valid) w_next = r_op_wr ? c_st_data : c_st_bus;
            c_st_data:
                if (r_rx_ferr)       w_next = c_st_idle;
                else if (r_rx_valid) w_next = c_st_bus;
            c_st_bus:
                if (bus_en)          w_next = r_op_wr ? c_st_resp : c_st_capture;
            c_st_capture:            w_next = c_st_resp;
            c_st_resp:
                if (!r_tx_busy)      w_next = c_st_idle;
            default:                 w_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_rx_take = 1'b0;
        w_tx_load = 1'b0;
        w_cs      = 1'b0;
        w_we      = 1'b0;
        case (r_state)
            c_st_idle:                            w_rx_take = r_rx_valid;
            c_st_addr_hi, c_st_addr_lo, c_st_data: w_rx_take = r_rx_valid && !r_rx_ferr;
            c_st_bus: begin
                w_cs = bus_en;
                w_we = bus_en && r_op_wr;
            end
            c_st_resp:                            w_tx_load = !r_tx_busy;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_wr <= 1'b0;
            r_addr  <= 16'h0000;
            r_dbw   <= 8'h00;
            r_resp  <= 8'h00;
        end else begin
            case (r_state)
                c_st_idle:
                    if (r_rx_valid) begin
                        r_op_wr <= (r_rx_byte == c_cmd_w);
                        if (r_rx_byte != c_cmd_w && r_rx_byte != c_cmd_r)
                            r_resp <= c_resp_bad;
                    end
                c_st_addr_hi: if (w_rx_take) r_addr[15:8] <= r_rx_byte;
                c_st_addr_lo: if (w_rx_take) r_addr[7:0]  <= r_rx_byte;
                c_st_data:    if (w_rx_take) r_dbw        <= r_rx_byte;
                c_st_bus:     if (bus_en && r_op_wr) r_resp <= c_resp_ok;
                c_st_capture: r_resp <= dbr;
                default: ;
            endcase
        end
    end

    assign tx   = r_tx;
    assign cs   = w_cs;
    assign we   = w_we;
    assign addr = r_addr;
    assign dbw  = r_dbw;

endmodule

`default_nettype wire

// File: tb/tb_uart_bridge.sv
// ============================================================================
// Module   : tb_uart_bridge
// Function : Directed bench for uart_bridge at DIV=14 with a simple bus target.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_bridge;

    localparam int c_baud = 115200;
    localparam int c_div  = 14;

    logic        clk = 1'b0, rst = 1'b0, rx = 1'b1, bus_en = 1'b1;
    logic [7:0]  dbr = 8'hFF, rd_val = 8'hFF;
    logic        tx, cs, we;
    logic [15:0] addr;
    logic [7:0]  dbw;

    uart_bridge #(.CLK_HZ(c_baud * c_div), .BAUD(c_baud)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .bus_en(bus_en),
        .cs(cs), .we(we), .addr(addr), .dbw(dbw), .dbr(dbr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          cs_cnt = 0, tx_low_cnt = 0, cs_cyc = 0;
    logic        cap_we;
    logic [15:0] cap_addr;
    logic [7:0]  cap_dbw;
    always @(negedge clk) begin
        if (cs === 1'b1) begin
            cs_cnt++;
            cs_cyc   = cyc;
            cap_we   = we;
            cap_addr = addr;
            cap_dbw  = dbw;
        end
        if (tx === 1'b0) tx_low_cnt++;
    end

    // Target presents read data only during the clock after the strobe
    initial begin
        forever begin
            @(negedge clk);
            if (cs === 1'b1) begin
                @(posedge clk); #1 dbr = rd_val;
                @(posedge clk); #1 dbr = 8'hFF;
            end
        end
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopb);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = fr[k];
            repeat (c_div) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        if (!stopb) begin
            repeat (c_div) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input logic [31:0] bytes, input int n);
        for (int k = 0; k < n; k++) send_byte(bytes[31-8*k -: 8], 1'b1);
    endtask

    // Samples each bit near both ends so a wrong bit period shows up
    task automatic recv_byte(output logic [7:0] b, output bit good);
        int n;
        logic v1, v2;
        logic [9:0] fr;
        good = 1'b1;
        b = 8'h00;
        fr = '0;
        n = 0;
        @(negedge clk);
        while (tx !== 1'b0) begin
            if (n >= 4000) begin
                good = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            v1 = tx;
            repeat (12) @(negedge clk);
            v2 = tx;
            fr[k] = v2;
            if (v1 !== v2) good = 1'b0;
            if (k < 9) @(negedge clk);
        end
        if (fr[0] !== 1'b0 || fr[9] !== 1'b1) good = 1'b0;
        b = fr[8:1];
    endtask

    typedef struct {
        logic [31:0] bytes;
        int          n;
        logic [7:0]  rd;
        int          exp_cs;
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [7:0]  exp_dbw;
        logic [7:0]  exp_resp;
    } vec_t;

    vec_t        vec[5];
    logic [7:0]  rb, rb2;
    bit          ok, ok2;
    int          base, txbase, rise;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec[0] = '{32'h571234A5, 4, 8'hFF, 1, 1'b1, 16'h1234, 8'hA5, 8'h2E};
        vec[1] = '{32'h52BEEF00, 3, 8'h5C, 1, 1'b0, 16'hBEEF, 8'h00, 8'h5C};
        vec[2] = '{32'h41000000, 1, 8'hFF, 0, 1'b0, 16'h0000, 8'h00, 8'h3F};
        vec[3] = '{32'h57FFFF00, 4, 8'hFF, 1, 1'b1, 16'hFFFF, 8'h00, 8'h2E};
        vec[4] = '{32'h52000000, 3, 8'h80, 1, 1'b0, 16'h0000, 8'h00, 8'h80};

        #12;
        check("reset_tx", tx, 1);
        check("reset_cs", cs, 0);
        check("reset_we", we, 0);
        check("reset_addr", addr, 16'h0000);
        check("reset_dbw", dbw, 8'h00);
        @(posedge clk); #1 rst = 1'b1;

        base = cs_cnt; txbase = tx_low_cnt;
        repeat (1000) @(posedge clk);
        #1;
        check("idle_cs", cs_cnt - base, 0);
        check("idle_tx", tx_low_cnt - txbase, 0);

        for (int i = 0; i < 5; i++) begin
            base = cs_cnt;
            rd_val = vec[i].rd;
            fork
                send_pkt(vec[i].bytes, vec[i].n);
                recv_byte(rb, ok);
            join
            repeat (5) @(posedge clk);
            #1;
            check($sformatf("v%0d_cs_count", i), cs_cnt - base, vec[i].exp_cs);
            if (vec[i].exp_cs != 0) begin
                check($sformatf("v%0d_we", i), cap_we, vec[i].exp_we);
                check($sformatf("v%0d_addr", i), cap_addr, vec[i].exp_addr);
                if (vec[i].exp_we) check($sformatf("v%0d_dbw", i), cap_dbw, vec[i].exp_dbw);
            end
            check($sformatf("v%0d_frame_ok", i), ok, 1);
            check($sformatf("v%0d_resp", i), rb, vec[i].exp_resp);
        end

        // Grant stall: strobe must wait for bus_en and fire on its first high clock
        bus_en = 1'b0;
        base = cs_cnt;
        rise = 0;
        fork
            begin
                send_pkt(32'h57ABCD3C, 4);
                repeat (200) @(posedge clk);
                #1;
                check("stall_no_cs", cs_cnt - base, 0);
                bus_en = 1'b1;
                rise = cyc;
            end
            recv_byte(rb, ok);
        join
        check("stall_cs_count", cs_cnt - base, 1);
        check("stall_cs_cycle", cs_cyc, rise);
        check("stall_addr", cap_addr, 16'hABCD);
        check("stall_dbw", cap_dbw, 8'h3C);
        check("stall_resp", rb, 8'h2E);

        // Framing error mid-packet aborts silently
        base = cs_cnt; txbase = tx_low_cnt;
        send_byte(8'h57, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        repeat (300) @(posedge clk);
        #1;
        check("ferr_no_cs", cs_cnt - base, 0);
        check("ferr_no_tx", tx_low_cnt - txbase, 0);
        rd_val = 8'h5C;
        fork
            send_pkt(32'h52BEEF00, 3);
            recv_byte(rb, ok);
        join
        check("ferr_read_cs", cs_cnt - base, 1);
        check("ferr_read_addr", cap_addr, 16'hBEEF);
        check("ferr_read_resp", rb, 8'h5C);
        check("ferr_read_ok", ok, 1);

        // Back-to-back packets overlapping the first response
        base = cs_cnt;
        rd_val = 8'hA7;
        fork
            begin
                send_pkt(32'h52123400, 3);
                send_pkt(32'h57001099, 4);
            end
            begin
                recv_byte(rb, ok);
                recv_byte(rb2, ok2);
            end
        join
        repeat (5) @(posedge clk);
        #1;
        check("b2b_cs_count", cs_cnt - base, 2);
        check("b2b_resp1", rb, 8'hA7);
        check("b2b_resp2", rb2, 8'h2E);
        check("b2b_ok", {ok, ok2}, 2'b11);
        check("b2b_addr", cap_addr, 16'h0010);
        check("b2b_dbw", cap_dbw, 8'h99);

        // Asynchronous reset while the response start bit is on the line
        send_byte(8'h41, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("midframe_tx_low", tx, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midframe_rst_tx", tx, 1);
        check("midframe_rst_addr", addr, 16'h0000);
        check("midframe_rst_dbw", dbw, 8'h00);
        @(posedge clk); #1 rst = 1'b1;
        txbase = tx_low_cnt;
        repeat (300) @(posedge clk);
        #1;
        check("post_rst_quiet", tx_low_cnt - txbase, 0);
        fork
            send_pkt(32'h58000000, 1);
            recv_byte(rb, ok);
        join
        check("post_rst_resp", rb, 8'h3F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_bridge.md
# uart_bridge

Serial-to-bus debug bridge for the 6502 system: receives 8N1 command packets from a host on `rx`, performs single-byte reads or writes on the 6502-side memory bus, and returns a one-byte response on `tx`. It is the bus initiator that drives the same `addr`/`dbw`/`we`/`dbr` interface our bus peripherals respond to. It is used for loading and inspecting memory while the CPU is held off the bus through `bus_en`.

## Interface
- `CLK_HZ`, default 12000000: system clock frequency in Hz.
- `BAUD`, default 115200: serial bit rate. Bit period `DIV = (CLK_HZ + BAUD/2) / BAUD` clocks, integer, ≥ 4.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rx` in 1: serial input, idle high, asynchronous to `clk`.
- `tx` out 1: serial output, idle high.
- `bus_en` in 1: bus grant; bridge may start a bus cycle only while high.
- `cs` out 1: bus cycle strobe, one clock wide.
- `we` out 1: write enable, valid with `cs`.
- `addr` out 16: bus address, held stable from `cs` until the next command.
- `dbw` out 8: write data, valid with `cs`.
- `dbr` in 8: read data from the target, sampled on the clock edge ending the cycle after `cs`.

## Operation
- Reset values: `tx`=1, `cs`=0, `we`=0, `addr`=0x0000, `dbw`=0x00. FSM in IDLE, rx/tx engines idle, byte-valid flag cleared.
- Receiver:
  - `rx` passes through a 2-flop synchronizer.
  - Falling edge in idle starts a frame. Start bit is re-checked at DIV/2; if high, the frame is a glitch and is dropped.
  - 8 data bits, LSB first, are sampled every DIV clocks after the start mid-point, followed by the stop bit.
  - Stop = 1: byte is latched and the valid flag set for the FSM.
  - Stop = 0: framing error pulse, no byte delivered.
  - A new byte overwrites an unconsumed one.
- Transmitter: 10-bit frame (start 0, 8 data bits LSB first, stop 1), each bit exactly DIV clocks. Loading is accepted only when idle.
- Packets:
  - Write: `'W'` (0x57), addr_hi, addr_lo, data → bus write, response `'.'` (0x2E).
  - Read: `'R'` (0x52), addr_hi, addr_lo → bus read, response = read byte.
  - Any other first byte → response `'?'` (0x3F), no bus cycle.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA, BUS, CAPTURE, RESP.
  - IDLE: on a byte, 'W'/'R' latch the op and go to ADDR_HI; any other byte loads 0x3F and goes to RESP.
  - ADDR_HI → ADDR_LO → DATA (write) or BUS (read), each advancing on a received byte.
  - DATA: latches `dbw`, then goes to BUS.
  - BUS: waits for `bus_en`=1, then asserts `cs` for one clock with `we`=op_is_write. A write goes to RESP with 0x2E; a read goes to CAPTURE.
  - CAPTURE: latches `dbr`, then goes to RESP.
  - RESP: waits for the tx engine to be idle, loads the response, then returns to IDLE.
- Framing error in any state other than IDLE: abort the packet, return to IDLE, send no response, issue no bus cycle. An abort in BUS, CAPTURE or RESP is ignored; those states complete.
- Bytes arriving during BUS, CAPTURE or RESP are held in the rx byte register and consumed after the return to IDLE.

## Timing
- Rx: byte-valid rises at the stop-bit sample point, 9.5·DIV clocks after the synchronized falling edge (plus 2 synchronizer clocks).
- Write: `cs` asserts on the clock after the data byte's valid, if `bus_en`=1. Otherwise it asserts on the first clock with `bus_en`=1.
- Read: `dbr` is captured exactly one clock after `cs`.
- Tx start bit begins on the clock after the load in RESP.
- `bus_en` may drop at any time. Once `cs` is asserted, the cycle is never retracted or repeated.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous), and any partial frame or packet is discarded.

## Test plan
Bench settings: CLK_HZ=115200·14, BAUD=115200, so DIV=14.
- Reset: `rst`=0 → `tx`=1, `cs`=0, `we`=0, `addr`=0x0000. After release, no activity for 1000 clocks with `rx`=1.
- Write: send 0x57, 0x12, 0x34, 0xA5 with `bus_en`=1 → exactly one clock with `cs`=1, `we`=1, `addr`=0x1234, `dbw`=0xA5. `tx` then sends 0x2E, each bit 14 clocks.
- Read: send 0x52, 0xBE, 0xEF with the target driving `dbr`=0x5C → one `cs` clock with `we`=0, `addr`=0xBEEF. `tx` sends start, then bits 0,0,1,1,1,0,1,0, then stop.
- Unknown command and grant stall:
  - Send 0x41 → `tx` sends 0x3F, `cs` never asserts.
  - Write packet with `bus_en`=0 for 200 clocks → `cs` is held off and asserts on the first clock after `bus_en` rises.
- Framing error: send 0x57, 0x12, then a byte with stop bit 0 → no `cs`, no tx response. A following valid read packet completes normally.
- Back-to-back: send the next packet immediately after a read packet → first response completes, second bus cycle occurs, second response follows with no lost bytes.
- Reset mid-frame: `rst` low while tx is mid-frame → `tx`=1 on reset assertion.
